issue_control_unit: RTL and testbench

- Issue stage controller between the decode unit and the four execution units (INT, BRU, LSU, VEC).
- Accepts one decoded instruction per cycle over a valid/ready handshake.
- Blocks issue on RAW/WAW register hazards (scoreboard), a busy target unit, or a full in-flight window.
- Sequences the invalid-instruction trap: drain the in-flight instructions, then hold the exception until flush.

---
 rtl/core101_issue_pkg.sv | 19 +
 rtl/issue_scoreboard.sv | 48 ++++
 rtl/issue_control_unit.sv | 127 ++++++++++++
 tb/tb_issue_control_unit.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core101_issue_pkg.sv
// Shared types and constants for the issue stage: unit selects, FSM states, field widths.
package core101_issue_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned UOP_W      = 4;
  localparam int unsigned NUM_REGS   = 1 << REG_ADDR_W;

  localparam logic [3:0] UNIT_INT = 4'b0001;
  localparam logic [3:0] UNIT_BRU = 4'b0010;
  localparam logic [3:0] UNIT_LSU = 4'b0100;
  localparam logic [3:0] UNIT_VEC = 4'b1000;

  typedef enum logic [1:0] {
    StRun   = 2'b00,
    StDrain = 2'b01,
    StTrap  = 2'b10
  } issue_state_e;

endpackage

// File: rtl/issue_scoreboard.sv
// Register-pending scoreboard: one bit per architectural register, set on issue and
// cleared on writeback, with three combinational read ports and a synchronous clear.
module issue_scoreboard
  import core101_issue_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clear,
  input  logic                  i_set_en,
  input  logic [REG_ADDR_W-1:0] i_set_addr,
  input  logic                  i_clr_en,
  input  logic [REG_ADDR_W-1:0] i_clr_addr,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_a,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_b,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_c,
  output logic                  o_busy_a,
  output logic                  o_busy_b,
  output logic                  o_busy_c
);

  logic [NUM_REGS-1:0] r_sb;
  logic [NUM_REGS-1:0] w_sb_d;

  // Set is applied after clear so a same-bit collision leaves the bit set; x0 never tracks.
  always_comb begin
    w_sb_d = r_sb;
    if (i_clr_en) begin
      w_sb_d[i_clr_addr] = 1'b0;
    end
    if (i_set_en) begin
      w_sb_d[i_set_addr] = 1'b1;
    end
    w_sb_d[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_sb <= '0;
    end else begin
      r_sb <= w_sb_d;
    end
  end

  assign o_busy_a = r_sb[i_rd_addr_a];
  assign o_busy_b = r_sb[i_rd_addr_b];
  assign o_busy_c = r_sb[i_rd_addr_c];

endmodule

// File: rtl/issue_control_unit.sv
// Issue stage controller: hazard/busy/window gating toward four execution units and the
// invalid-instruction drain-then-trap sequence.
module issue_control_unit
  import core101_issue_pkg::*;
#(
  parameter int unsigned NUM_UNITS    = 4,
  parameter int unsigned MAX_INFLIGHT = 8,
  parameter int unsigned CNT_W        = 4
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  dec_valid_in,
  output logic                  dec_ready_out,
  input  logic [NUM_UNITS-1:0]  dec_exec_unit_sel_in,
  input  logic [UOP_W-1:0]      dec_exec_unit_uop_in,
  input  logic                  dec_rd_write_enable_in,
  input  logic                  dec_invalid_ins_in,
  input  logic [REG_ADDR_W-1:0] dec_rd_in,
  input  logic [REG_ADDR_W-1:0] dec_rs1_in,
  input  logic [REG_ADDR_W-1:0] dec_rs2_in,
  input  logic [1:0]            dec_rs_used_in,
  input  logic [NUM_UNITS-1:0]  unit_busy_in,
  input  logic [NUM_UNITS-1:0]  unit_done_in,
  input  logic                  wb_valid_in,
  input  logic [REG_ADDR_W-1:0] wb_rd_in,
  input  logic                  flush_in,
  output logic [NUM_UNITS-1:0]  issue_valid_out,
  output logic [UOP_W-1:0]      issue_uop_out,
  output logic [REG_ADDR_W-1:0] issue_rd_out,
  output logic                  exc_valid_out,
  output logic [CNT_W-1:0]      inflight_out
);

  localparam int unsigned SumW = CNT_W + 1;

  issue_state_e          r_state;
  issue_state_e          w_state_d;
  logic [CNT_W-1:0]      r_inflight;
  logic [NUM_UNITS-1:0]  r_issue_valid;
  logic [UOP_W-1:0]      r_uop;
  logic [REG_ADDR_W-1:0] r_rd;
  logic                  r_exc;

  logic w_rs1_pend, w_rs2_pend, w_rd_pend;
  logic w_bad, w_hazard, w_unit_busy, w_window_full;
  logic w_issue_ok, w_bad_accept;
  logic [SumW-1:0] w_cnt_sum, w_done_cnt, w_cnt_next;

  issue_scoreboard u_scoreboard (
    .i_clk       (clock_in),
    .i_rst       (reset_in),
    .i_clear     (flush_in),
    .i_set_en    (w_issue_ok & dec_rd_write_enable_in),
    .i_set_addr  (dec_rd_in),
    .i_clr_en    (wb_valid_in),
    .i_clr_addr  (wb_rd_in),
    .i_rd_addr_a (dec_rs1_in),
    .i_rd_addr_b (dec_rs2_in),
    .i_rd_addr_c (dec_rd_in),
    .o_busy_a    (w_rs1_pend),
    .o_busy_b    (w_rs2_pend),
    .o_busy_c    (w_rd_pend)
  );

  assign w_bad = dec_invalid_ins_in | ($countones(dec_exec_unit_sel_in) != 1);

  // Registered scoreboard only: a same-cycle writeback does not bypass.
  assign w_hazard = (w_rs1_pend & dec_rs_used_in[0] & (dec_rs1_in != '0))
                  | (w_rs2_pend & dec_rs_used_in[1] & (dec_rs2_in != '0))
                  | (w_rd_pend & dec_rd_write_enable_in & (dec_rd_in != '0));

  assign w_unit_busy   = (unit_busy_in & dec_exec_unit_sel_in) != '0;
  assign w_window_full = r_inflight >= CNT_W'(MAX_INFLIGHT);

  assign w_issue_ok = (r_state == StRun) & dec_valid_in & ~w_bad & ~w_hazard & ~w_unit_busy
                    & ~w_window_full & ~flush_in;
  assign w_bad_accept = (r_state == StRun) & dec_valid_in & w_bad & ~flush_in;

  assign dec_ready_out = ~reset_in & (w_issue_ok | w_bad_accept);

  // Completions beyond the current count are dropped rather than wrapping.
  assign w_cnt_sum  = {1'b0, r_inflight} + {{CNT_W{1'b0}}, w_issue_ok};
  assign w_done_cnt = SumW'($countones(unit_done_in));
  assign w_cnt_next = (w_cnt_sum > w_done_cnt) ? (w_cnt_sum - w_done_cnt) : '0;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StRun:   if (w_bad_accept) w_state_d = StDrain;
      StDrain: if (w_cnt_next == '0) w_state_d = StTrap;
      StTrap:  w_state_d = StTrap;
      default: w_state_d = StRun;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      r_state       <= StRun;
      r_inflight    <= '0;
      r_issue_valid <= '0;
      r_uop         <= '0;
      r_rd          <= '0;
      r_exc         <= 1'b0;
    end else if (flush_in) begin
      r_state       <= StRun;
      r_inflight    <= '0;
      r_issue_valid <= '0;
      r_exc         <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_inflight    <= w_cnt_next[CNT_W-1:0];
      r_issue_valid <= w_issue_ok ? dec_exec_unit_sel_in : '0;
      r_exc         <= (w_state_d == StTrap);
      if (w_issue_ok) begin
        r_uop <= dec_exec_unit_uop_in;
        r_rd  <= dec_rd_in;
      end
    end
  end

  assign issue_valid_out = r_issue_valid;
  assign issue_uop_out   = r_uop;
  assign issue_rd_out    = r_rd;
  assign exc_valid_out   = r_exc;
  assign inflight_out    = r_inflight;

endmodule

// File: tb/tb_issue_control_unit.sv
// Self-checking bench for issue_control_unit: directed scenarios plus randomized traffic,
// all compared against a cycle-level behavioural model of the issue rules.
module tb_issue_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic       ready;
  logic [3:0] sel;
  logic [3:0] uop;
  logic       we;
  logic       inv;
  logic [4:0] rd, rs1, rs2;
  logic [1:0] used;
  logic [3:0] busy;
  logic [3:0] done;
  logic       wbv;
  logic [4:0] wbrd;
  logic       flush;
  logic [3:0] issue_valid;
  logic [3:0] issue_uop;
  logic [4:0] issue_rd;
  logic       exc;
  logic [3:0] inflight;

  int n_checks = 0;
  int n_errors = 0;

  issue_control_unit dut (
    .clock_in               (clk),
    .reset_in               (rst),
    .dec_valid_in           (valid),
    .dec_ready_out          (ready),
    .dec_exec_unit_sel_in   (sel),
    .dec_exec_unit_uop_in   (uop),
    .dec_rd_write_enable_in (we),
    .dec_invalid_ins_in     (inv),
    .dec_rd_in              (rd),
    .dec_rs1_in             (rs1),
    .dec_rs2_in             (rs2),
    .dec_rs_used_in         (used),
    .unit_busy_in           (busy),
    .unit_done_in           (done),
    .wb_valid_in            (wbv),
    .wb_rd_in               (wbrd),
    .flush_in               (flush),
    .issue_valid_out        (issue_valid),
    .issue_uop_out          (issue_uop),
    .issue_rd_out           (issue_rd),
    .exc_valid_out          (exc),
    .inflight_out           (inflight)
  );

  always #5 clk = ~clk;

  // Behavioural model: pending-register set, plain integer window count, mode number.
  bit [31:0]  m_pend;
  int         m_cnt;
  int         m_mode;  // 0 normal, 1 waiting for drain, 2 trap held
  logic [3:0] m_iv, m_uop;
  logic [4:0] m_rd;
  logic       m_exc;

  function automatic bit m_bad();
    return inv || ($countones(sel) != 1);
  endfunction

  function automatic bit m_hazard();
    return (used[0] && rs1 != 0 && m_pend[rs1]) || (used[1] && rs2 != 0 && m_pend[rs2])
        || (we && rd != 0 && m_pend[rd]);
  endfunction

  function automatic bit m_issue();
    return !rst && m_mode == 0 && valid && !m_bad() && !m_hazard() && ((busy & sel) == 0)
        && m_cnt < 8 && !flush;
  endfunction

  function automatic bit m_ready();
    return !rst && (m_issue() || (m_mode == 0 && valid && m_bad() && !flush));
  endfunction

  function automatic void m_clock();
    bit ok;
    int n;
    if (rst) begin
      m_pend = '0; m_cnt = 0; m_mode = 0; m_iv = 0; m_uop = 0; m_rd = 0; m_exc = 0;
    end else if (flush) begin
      m_pend = '0; m_cnt = 0; m_mode = 0; m_iv = 0; m_exc = 0;
    end else begin
      ok = m_issue();
      n = m_cnt + (ok ? 1 : 0) - $countones(done);
      if (n < 0) n = 0;
      if (wbv) m_pend[wbrd] = 1'b0;
      if (ok && we && rd != 0) m_pend[rd] = 1'b1;
      if (m_mode == 0 && valid && m_bad()) m_mode = 1;
      else if (m_mode == 1 && n == 0) m_mode = 2;
      m_iv = ok ? sel : 4'b0000;
      if (ok) begin
        m_uop = uop;
        m_rd  = rd;
      end
      m_exc = (m_mode == 2);
      m_cnt = n;
    end
  endfunction

  task automatic set_idle();
    rst = 0; valid = 0; sel = 4'b0001; uop = 0; we = 0; inv = 0; rd = 0; rs1 = 0; rs2 = 0;
    used = 0; busy = 0; done = 0; wbv = 0; wbrd = 0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    m_clock();
    #1;
  endtask

  task automatic do_flush();
    set_idle();
    flush = 1;
    tick();
    flush = 0;
  endtask

  task automatic present(input logic [3:0] s, input logic [3:0] u, input logic [4:0] d,
                         input logic w);
    valid = 1; sel = s; uop = u; rd = d; we = w; inv = 0; used = 0;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1;
    present(4'b0001, 4'h5, 5'd4, 1);
    #1;
    n_checks++;
    if (ready !== 1'b0) begin
      n_errors++; $display("FAIL reset_ready: got %b want 0", ready);
    end
    tick();
    tick();
    n_checks++;
    if ({issue_valid, issue_uop, issue_rd, exc, inflight} !== 18'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: got iv=%b uop=%h rd=%0d exc=%b cnt=%0d want all 0",
               issue_valid, issue_uop, issue_rd, exc, inflight);
    end
    set_idle();
  endtask

  task automatic test_basic_issue();
    present(4'b0001, 4'b0000, 5'd3, 1);
    #1;
    n_checks++;
    if (ready !== 1'b1) begin n_errors++; $display("FAIL add_ready: got %b want 1", ready); end
    tick();
    n_checks++;
    if (issue_valid !== 4'b0001 || issue_rd !== 5'd3 || inflight !== 4'd1) begin
      n_errors++;
      $display("FAIL add_issue: got iv=%b rd=%0d cnt=%0d want 0001 3 1",
               issue_valid, issue_rd, inflight);
    end
    valid = 0;
    tick();
    n_checks++;
    if (issue_valid !== 4'b0000 || issue_rd !== 5'd3) begin
      n_errors++;
      $display("FAIL add_pulse: got iv=%b rd=%0d want 0000 3 (held)", issue_valid, issue_rd);
    end
    do_flush();
  endtask

  task automatic test_raw_hazard();
    present(4'b0001, 4'h1, 5'd5, 1);
    tick();
    present(4'b0001, 4'h2, 5'd6, 1);
    rs1 = 5'd5; used = 2'b01;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (ready !== 1'b0) begin
        n_errors++; $display("FAIL raw_stall: cycle %0d got ready=%b want 0", i, ready);
      end
      tick();
    end
    wbv = 1; wbrd = 5'd5;
    #1;
    n_checks++;
    if (ready !== 1'b0) begin
      n_errors++; $display("FAIL raw_no_bypass: got ready=%b want 0", ready);
    end
    tick();
    wbv = 0;
    #1;
    n_checks++;
    if (ready !== 1'b1) begin
      n_errors++; $display("FAIL raw_release: got ready=%b want 1", ready);
    end
    tick();
    n_checks++;
    if (issue_valid !== 4'b0001 || issue_rd !== 5'd6 || issue_uop !== 4'h2) begin
      n_errors++;
      $display("FAIL raw_issue: got iv=%b rd=%0d uop=%h want 0001 6 2",
               issue_valid, issue_rd, issue_uop);
    end
    do_flush();
  endtask

  task automatic test_busy();
    busy = 4'b0100;
    present(4'b0100, 4'b0011, 5'd7, 1);
    #1;
    n_checks++;
    if (ready !== 1'b0) begin n_errors++; $display("FAIL busy_stall: got %b want 0", ready); end
    tick();
    n_checks++;
    if (issue_valid !== 4'b0000) begin
      n_errors++; $display("FAIL busy_noissue: got iv=%b want 0000", issue_valid);
    end
    busy = 4'b0000;
    tick();
    n_checks++;
    if (issue_valid !== 4'b0100 || issue_uop !== 4'b0011) begin
      n_errors++;
      $display("FAIL busy_issue: got iv=%b uop=%b want 0100 0011", issue_valid, issue_uop);
    end
    do_flush();
  endtask

  task automatic test_window_full();
    present(4'b0010, 4'h4, 5'd0, 0);
    for (int i = 0; i < 8; i++) tick();
    #1;
    n_checks++;
    if (inflight !== 4'd8 || ready !== 1'b0) begin
      n_errors++;
      $display("FAIL window_full: got cnt=%0d ready=%b want 8 0", inflight, ready);
    end
    done = 4'b0011;
    tick();
    done = 4'b0000;
    #1;
    n_checks++;
    if (inflight !== 4'd6 || ready !== 1'b1) begin
      n_errors++;
      $display("FAIL window_resume: got cnt=%0d ready=%b want 6 1", inflight, ready);
    end
    tick();
    n_checks++;
    if (inflight !== 4'd7 || issue_valid !== 4'b0010) begin
      n_errors++;
      $display("FAIL window_reissue: got cnt=%0d iv=%b want 7 0010", inflight, issue_valid);
    end
    do_flush();
  endtask

  task automatic test_trap();
    present(4'b1000, 4'h9, 5'd0, 0);
    tick();
    tick();
    inv = 1;
    #1;
    n_checks++;
    if (ready !== 1'b1) begin n_errors++; $display("FAIL trap_accept: got %b want 1", ready); end
    tick();
    n_checks++;
    if (issue_valid !== 4'b0000 || exc !== 1'b0 || inflight !== 4'd2) begin
      n_errors++;
      $display("FAIL trap_drain: got iv=%b exc=%b cnt=%0d want 0000 0 2",
               issue_valid, exc, inflight);
    end
    inv = 0; valid = 0; done = 4'b0001;
    tick();
    n_checks++;
    if (exc !== 1'b0 || inflight !== 4'd1) begin
      n_errors++; $display("FAIL trap_wait: got exc=%b cnt=%0d want 0 1", exc, inflight);
    end
    tick();
    done = 4'b0000;
    present(4'b0001, 4'h1, 5'd2, 1);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (exc !== 1'b1 || ready !== 1'b0 || inflight !== 4'd0) begin
        n_errors++;
        $display("FAIL trap_hold: cycle %0d got exc=%b ready=%b cnt=%0d want 1 0 0",
                 i, exc, ready, inflight);
      end
      tick();
    end
    flush = 1;
    tick();
    flush = 0;
    #1;
    n_checks++;
    if (exc !== 1'b0 || ready !== 1'b1) begin
      n_errors++; $display("FAIL trap_flush: got exc=%b ready=%b want 0 1", exc, ready);
    end
    do_flush();
  endtask

  task automatic test_flush();
    present(4'b0001, 4'h1, 5'd9, 1);
    tick();
    present(4'b0001, 4'h2, 5'd10, 1);
    rs1 = 5'd9; used = 2'b01; flush = 1;
    #1;
    n_checks++;
    if (ready !== 1'b0) begin n_errors++; $display("FAIL flush_reject: got %b want 0", ready); end
    tick();
    flush = 0;
    #1;
    n_checks++;
    if (inflight !== 4'd0 || issue_valid !== 4'b0000 || ready !== 1'b1) begin
      n_errors++;
      $display("FAIL flush_clear: got cnt=%0d iv=%b ready=%b want 0 0000 1",
               inflight, issue_valid, ready);
    end
    do_flush();
  endtask

  task automatic test_random();
    logic [17:0] got, want;
    for (int i = 0; i < 1500; i++) begin
      rst   = ($urandom_range(0, 149) == 0);
      flush = ($urandom_range(0, 39) == 0);
      valid = ($urandom_range(0, 9) < 7);
      inv   = ($urandom_range(0, 24) == 0);
      sel   = ($urandom_range(0, 9) < 8) ? (4'b0001 << $urandom_range(0, 3))
                                         : 4'($urandom_range(0, 15));
      uop   = 4'($urandom_range(0, 15));
      we    = ($urandom_range(0, 9) < 6);
      rd    = 5'($urandom_range(0, 7));
      rs1   = 5'($urandom_range(0, 7));
      rs2   = 5'($urandom_range(0, 7));
      used  = 2'($urandom_range(0, 3));
      busy  = 4'($urandom & $urandom & $urandom);
      done  = 4'($urandom & $urandom);
      wbv   = ($urandom_range(0, 2) == 0);
      wbrd  = 5'($urandom_range(0, 7));
      #1;
      n_checks++;
      if (ready !== m_ready()) begin
        n_errors++; $display("FAIL rand_ready: cycle %0d got %b want %b", i, ready, m_ready());
      end
      tick();
      got  = {issue_valid, issue_uop, issue_rd, exc, inflight};
      want = {m_iv, m_uop, m_rd, m_exc, 4'(m_cnt)};
      n_checks++;
      if (got !== want) begin
        n_errors++;
        $display("FAIL rand_outputs: cycle %0d got iv=%b uop=%h rd=%0d exc=%b cnt=%0d want iv=%b uop=%h rd=%0d exc=%b cnt=%0d",
                 i, issue_valid, issue_uop, issue_rd, exc, inflight,
                 m_iv, m_uop, m_rd, m_exc, m_cnt);
      end
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    test_reset();
    test_basic_issue();
    test_raw_hazard();
    test_busy();
    test_window_full();
    test_trap();
    test_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
